fft_frame_ctrl: RTL and testbench

FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

---
 rtl/fft_frame_ctrl.sv | 119 +++++++++++
 tb/tb_fft_frame_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for a serial-in / FFT / serial-out pipeline.
// Fills a SIPO, launches the FFT core, loads the PISO and drains it.
module fft_frame_ctrl #(
  parameter int unsigned N        = 16,
  parameter int unsigned CALC_LAT = 4,
  parameter bit          CONT     = 1'b0,
  localparam int unsigned IdxW    = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            sipo_en,
  output logic            calc_start,
  output logic            piso_load,
  output logic            piso_en,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            busy,
  output logic [IdxW-1:0] sample_idx
);

  localparam int unsigned CntW = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(N - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CALC_LAT - 1);

  typedef enum logic [2:0] {StIdle, StFill, StCalc, StLoad, StDrain} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    in_ready   = 1'b0;
    sipo_en    = 1'b0;
    calc_start = 1'b0;
    piso_load  = 1'b0;
    piso_en    = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    sample_idx = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFill;
          idx_d   = '0;
        end
      end
      StFill: begin
        in_ready   = 1'b1;
        sipo_en    = in_valid;
        sample_idx = idx_q;
        if (in_valid) begin
          if (idx_q == IdxLast) begin
            state_d = StCalc;
            idx_d   = '0;
            cnt_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StCalc: begin
        calc_start = (cnt_q == '0);
        if (cnt_q == CntLast) begin
          state_d = StLoad;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StLoad: begin
        piso_load = 1'b1;
        state_d   = StDrain;
        idx_d     = '0;
      end
      StDrain: begin
        out_valid  = 1'b1;
        piso_en    = out_ready;
        sample_idx = idx_q;
        out_last   = (idx_q == IdxLast);
        if (out_ready) begin
          if (idx_q == IdxLast) begin
            // Continuous mode chains straight into the next fill.
            state_d = CONT ? StFill : StIdle;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Randomised + directed bench for fft_frame_ctrl; a timeline model predicts
// every output of a one-shot and a continuous-mode instance each cycle.
module tb_fft_frame_ctrl;

  localparam int N = 16;
  localparam int L = 4;

  logic clk = 1'b0;
  logic rst, start, in_valid, out_ready;

  logic       in_ready0, sipo_en0, calc_start0, piso_load0, piso_en0;
  logic       out_valid0, out_last0, busy0;
  logic [3:0] idx0;
  logic       in_ready1, sipo_en1, calc_start1, piso_load1, piso_en1;
  logic       out_valid1, out_last1, busy1;
  logic [3:0] idx1;

  fft_frame_ctrl #(.N(N), .CALC_LAT(L), .CONT(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready0),
    .sipo_en(sipo_en0), .calc_start(calc_start0), .piso_load(piso_load0),
    .piso_en(piso_en0), .out_valid(out_valid0), .out_ready(out_ready),
    .out_last(out_last0), .busy(busy0), .sample_idx(idx0)
  );

  fft_frame_ctrl #(.N(N), .CALC_LAT(L), .CONT(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready1),
    .sipo_en(sipo_en1), .calc_start(calc_start1), .piso_load(piso_load1),
    .piso_en(piso_en1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_last(out_last1), .busy(busy1), .sample_idx(idx1)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: a frame is a timeline -- N accepts, then k counts cycles since the
  // last accept (calc window 1..L, load at L+1, drain from L+2), then N handshakes.
  bit m_act[2];
  int m_fill[2];
  int m_k[2];
  int m_d[2];
  bit m_cont[2] = '{1'b0, 1'b1};

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_act[i] = 1'b0; m_fill[i] = 0; m_k[i] = 0; m_d[i] = 0;
      end else if (!m_act[i]) begin
        if (start) begin
          m_act[i] = 1'b1; m_fill[i] = 0; m_k[i] = 0; m_d[i] = 0;
        end
      end else if (m_fill[i] < N) begin
        if (in_valid) begin
          m_fill[i]++;
          if (m_fill[i] == N) m_k[i] = 1;
        end
      end else if (m_k[i] <= L + 1) begin
        m_k[i]++;
      end else if (out_ready) begin
        if (m_d[i] == N - 1) begin
          m_fill[i] = 0; m_k[i] = 0; m_d[i] = 0;
          m_act[i] = m_cont[i];
        end else begin
          m_d[i]++;
        end
      end
    end
  end

  function automatic logic [11:0] exp_vec(input int i);
    logic [11:0] v;
    v = '0;
    if (rst || !m_act[i]) return v;
    v[11] = 1'b1;
    if (m_fill[i] < N) begin
      v[10] = 1'b1;
      v[9] = in_valid;
      v[3:0] = 4'(m_fill[i]);
    end else if (m_k[i] <= L) begin
      v[8] = (m_k[i] == 1);
    end else if (m_k[i] == L + 1) begin
      v[7] = 1'b1;
    end else begin
      v[6] = out_ready;
      v[5] = 1'b1;
      v[4] = (m_d[i] == N - 1);
      v[3:0] = 4'(m_d[i]);
    end
    return v;
  endfunction

  logic [11:0] act0, act1;
  assign act0 = {busy0, in_ready0, sipo_en0, calc_start0, piso_load0, piso_en0,
                 out_valid0, out_last0, idx0};
  assign act1 = {busy1, in_ready1, sipo_en1, calc_start1, piso_load1, piso_en1,
                 out_valid1, out_last1, idx1};

  bit prev_last_hs1 = 1'b0;

  always @(negedge clk) begin
    chk("model_cont0", 32'(act0), 32'(exp_vec(0)));
    chk("model_cont1", 32'(act1), 32'(exp_vec(1)));
    if (prev_last_hs1 && !rst) chk("cont_refill_in_ready", 32'(in_ready1), 32'd1);
    prev_last_hs1 = !rst && out_valid1 && out_last1 && out_ready;
  end

  // Per-frame event log of the one-shot instance, restarted on each accepted start.
  int n_sipo, n_piso, n_calc, n_load, first_acc, last_acc, t_calc, t_load, t_ov, t_last;

  always @(negedge clk) begin
    if (!rst) begin
      if (start && !busy0) begin
        n_sipo = 0; n_piso = 0; n_calc = 0; n_load = 0;
        first_acc = -1; last_acc = -1; t_calc = -1; t_load = -1; t_ov = -1; t_last = -1;
      end
      if (sipo_en0) begin
        n_sipo++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
      if (calc_start0) begin n_calc++; t_calc = cyc; end
      if (piso_load0) begin n_load++; t_load = cyc; end
      if (out_valid0 && t_ov < 0) t_ov = cyc;
      if (piso_en0) begin
        n_piso++;
        if (out_last0) t_last = cyc;
      end
    end
  end

  task automatic wait_idle0(input string name);
    int n = 0;
    while (busy0 !== 1'b0 && n < 500) begin step(); n++; end
    if (n >= 500) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wait_drain_idx(input int idx, input string name);
    int n = 0;
    while (!(out_valid0 === 1'b1 && idx0 == 4'(idx)) && n < 500) begin step(); n++; end
    if (n >= 500) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    chk("reset_outputs", 32'({act0, act1}), 32'd0);
    rst = 1'b0;
    step();

    // Basic frame with fixed latency.
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    wait_idle0("basic");
    chk("basic_sipo_count", 32'(n_sipo), 32'd16);
    chk("basic_calc_lat", 32'(t_calc - last_acc), 32'd1);
    chk("basic_load_lat", 32'(t_load - last_acc), 32'd5);
    chk("basic_ov_lat", 32'(t_ov - last_acc), 32'd6);
    chk("basic_pulses", 32'({n_calc[7:0], n_load[7:0], n_piso[7:0]}), 32'h010110);
    chk("basic_last_pos", 32'(t_last - t_ov), 32'd15);

    // Input bubbles plus backpressure at index 5.
    start = 1'b1; in_valid = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 31; c++) begin
      in_valid = (c % 2 == 0);
      step();
    end
    in_valid = 1'b0;
    chk("bubble_sipo_count", 32'(n_sipo), 32'd16);
    chk("bubble_span", 32'(last_acc - first_acc), 32'd30);
    wait_drain_idx(5, "bp");
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("bp_hold", 32'({out_valid0, piso_en0, idx0}), 32'h25);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_resume_hs", 32'({piso_en0, idx0}), 32'h15);
    step();
    chk("bp_next_idx", 32'(idx0), 32'd6);
    wait_idle0("bp");
    chk("bp_piso_count", 32'(n_piso), 32'd16);

    // start+in_valid together in IDLE; stray start during CALC.
    start = 1'b1; in_valid = 1'b1;
    #1;
    chk("idle_no_accept", 32'({sipo_en0, in_ready0}), 32'd0);
    step();
    start = 1'b0;
    begin
      int n = 0;
      while (calc_start0 !== 1'b1 && n < 100) begin step(); n++; end
      if (n >= 100) chk("calc_wait_timeout", 32'd1, 32'd0);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idle0("calc_start");
    chk("calc_start_frame", 32'({n_sipo[7:0], n_calc[7:0], n_load[7:0], n_piso[7:0]}),
        32'h10010110);

    // Asynchronous reset mid-drain.
    start = 1'b1;
    step();
    start = 1'b0;
    wait_drain_idx(9, "rst");
    rst = 1'b1;
    #1;
    chk("rst_mid_drain", 32'({act0, act1}), 32'd0);
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("rst_waits_idle", 32'({busy0, busy1}), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rst_refill", 32'({busy0, in_ready0, idx0}), 32'h30);
    wait_idle0("rst_refill");

    // Randomised traffic with rare resets.
    for (int c = 0; c < 4000; c++) begin
      start     = ($urandom % 8) == 0;
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      rst       = ($urandom % 600) == 0;
      step();
    end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
